// File: rtl/seg_scan_ctrl_if.sv
// Load bus for seg_scan_ctrl. The producer (counter or datapath) offers a
// 16-bit hex value with a load strobe. The scan controller returns a
// one-cycle ack when that value reaches the displayed shadow register.
interface seg_scan_ctrl_if;
   logic [15:0] value;
   logic        load;
   logic        ack;

   modport master (
      output value,
      output load,
      input  ack
   );

   modport slave (
      input  value,
      input  load,
      output ack
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Each digit slot shows one shadow nibble for DIV-BLANK cycles.
// All anodes are then held off for BLANK cycles so that ghosting is hidden
// while the shared segment bus changes.
// New values are buffered and copied into the shadow register only on the
// frame boundary, so one frame never mixes old and new digits.
module seg_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 2000
) (
   input  logic            clk,
   input  logic            rst,
   seg_scan_ctrl_if.slave  bus,
   input  logic            lz_en,
   output logic [6:0]      seg,
   output logic [3:0]      an,
   output logic            frame
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - BLANK - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

   if (BLANK < 1 || DIV <= BLANK) begin : g_bad_params
      $error("seg_scan_ctrl: need BLANK >= 1 and DIV > BLANK");
   end

   typedef enum logic {
      ST_SHOW,
      ST_BLANK
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [15:0]      capture_q, capture_d;
   logic             pending_q, pending_d;
   logic             ack_q, ack_d;
   logic             boundary;

   // Hex digit to active-low segments, bit order gfedcba.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // A digit counts as a leading zero when it and every digit to its left are zero.
   // Digit 0 is never treated as a leading zero, so a value of 0 still shows "0".
   function automatic logic is_leading_zero(input logic [15:0] v, input logic [1:0] i);
      logic z;
      case (i)
         2'd1:    z = (v[15:4]  == 12'h000);
         2'd2:    z = (v[15:8]  == 8'h00);
         2'd3:    z = (v[15:12] == 4'h0);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

   // State register for the slot sequencer and the load buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_BLANK;
         idx_q     <= 2'd3;
         cnt_q     <= '0;
         shadow_q  <= '0;
         capture_q <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         capture_q <= capture_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
      end
   end

   // Next-state logic: slot timing, digit rotation, and the frame-boundary shadow update.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + 1'b1;
      shadow_d  = shadow_q;
      capture_d = capture_q;
      pending_d = pending_q;
      ack_d     = 1'b0;
      boundary  = 1'b0;

      case (state_q)
         ST_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == BLANK_LAST) begin
               state_d  = ST_SHOW;
               idx_d    = idx_q + 2'd1;
               cnt_d    = '0;
               boundary = (idx_q == 2'd3);
            end
         end
      endcase

      // A load that lands on the boundary edge has priority over the buffered one.
      if (boundary) begin
         if (bus.load) begin
            shadow_d = bus.value;
         end else if (pending_q) begin
            shadow_d = capture_q;
         end
         ack_d     = bus.load | pending_q;
         pending_d = 1'b0;
      end else if (bus.load) begin
         capture_d = bus.value;
         pending_d = 1'b1;
      end
   end

   // Output decode: anodes and segments follow registered state only.
   // lz_en is the one live input and gates leading-zero segments.
   always_comb begin
      logic [3:0] nib;
      nib = shadow_q[{idx_q, 2'b00} +: 4];
      an  = 4'b1111;
      seg = 7'b1111111;
      if (state_q == ST_SHOW) begin
         an = ~(4'b0001 << idx_q);
         if (!(lz_en && is_leading_zero(shadow_q, idx_q))) begin
            seg = hex_to_seg(nib);
         end
      end
   end

   assign frame   = (state_q == ST_SHOW) && (idx_q == 2'd0) && (cnt_q == '0);
   assign bus.ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8 and BLANK=2, which gives a 32-cycle frame.
// Inputs change on the falling edge and outputs are sampled there too.
// Nk is the k-th falling edge after reset release. The frame boundary edges
// are the rising edges just before N2, N34, N66 and so on.
module tb_seg_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       lz_en;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame;
   int         checks;
   int         errors;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .DIV   (8),
      .BLANK (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .lz_en (lz_en),
      .seg   (seg),
      .an    (an),
      .frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at N0, the falling edge where rst is released.
   task automatic reset_dut();
      @(negedge clk);
      rst       = 1'b0;
      bus.load  = 1'b0;
      bus.value = 16'h0000;
      ticks(5);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      lz_en = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      bus.load  = 1'b0;
      bus.value = 16'h0000;
      ticks(2);
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || bus.ack !== 1'b0 || frame !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: an=%b seg=%h ack=%b frame=%b want 1111 7f 0 0", an, seg, bus.ack, frame);
      end
      ticks(3);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (an !== 4'b1111 || seg !== 7'h7F || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_blank N%0d: an=%b seg=%h frame=%b want 1111 7f 0", k, an, seg, frame);
         end
         ticks(1);
      end
      checks++;
      if (an !== 4'b1110 || seg !== 7'h40 || frame !== 1'b1 || bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_frame: an=%b seg=%h frame=%b ack=%b want 1110 40 1 0", an, seg, frame, bus.ack);
      end
      ticks(1);
      checks++;
      if (frame !== 1'b0) begin
         errors++;
         $display("FAIL frame_width: frame=%b want 0", frame);
      end
      ticks(31);
      checks++;
      if (frame !== 1'b1) begin
         errors++;
         $display("FAIL frame_period: frame=%b want 1", frame);
      end
   endtask

   task automatic test_scan_order();
      logic [6:0] ex [4];
      reset_dut();
      lz_en = 1'b0;
      ticks(5);
      bus.load  = 1'b1;
      bus.value = 16'h1234;
      ticks(1);
      bus.load = 1'b0;
      checks++;
      if (bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL scan_early_ack: ack=%b want 0", bus.ack);
      end
      ticks(1);
      checks++;
      if (an !== 4'b1110 || seg !== 7'h40) begin
         errors++;
         $display("FAIL scan_old_shadow: an=%b seg=%h want 1110 40", an, seg);
      end
      ticks(27);
      checks++;
      if (bus.ack !== 1'b1 || frame !== 1'b1) begin
         errors++;
         $display("FAIL scan_ack: ack=%b frame=%b want 1 1", bus.ack, frame);
      end
      ex = '{7'h19, 7'h30, 7'h24, 7'h79};
      for (int t = 0; t < 32; t++) begin
         int s;
         int o;
         logic [3:0] ea;
         logic [6:0] es;
         s = t / 8;
         o = t % 8;
         if (o < 6) begin
            ea = ~(4'b0001 << s);
            es = ex[s];
         end else begin
            ea = 4'b1111;
            es = 7'h7F;
         end
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL scan t=%0d: an=%b seg=%h want %b %h", t, an, seg, ea, es);
         end
         ticks(1);
      end
      checks++;
      if (bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL scan_no_reack: ack=%b want 0", bus.ack);
      end
   endtask

   task automatic test_overwrite();
      logic [6:0] ex [4];
      int acks;
      reset_dut();
      lz_en = 1'b0;
      ticks(4);
      bus.load  = 1'b1;
      bus.value = 16'hAAAA;
      ticks(1);
      bus.load = 1'b0;
      ticks(5);
      bus.load  = 1'b1;
      bus.value = 16'hBEEF;
      ticks(1);
      bus.load = 1'b0;
      acks = 0;
      for (int k = 11; k < 34; k++) begin
         if (bus.ack === 1'b1) acks++;
         ticks(1);
      end
      checks++;
      if (acks !== 0 || bus.ack !== 1'b1) begin
         errors++;
         $display("FAIL overwrite_ack: early acks=%0d ack=%b want 0 1", acks, bus.ack);
      end
      ex = '{7'h0E, 7'h06, 7'h06, 7'h03};
      for (int t = 0; t < 32; t++) begin
         int s;
         int o;
         logic [3:0] ea;
         logic [6:0] es;
         s = t / 8;
         o = t % 8;
         if (o < 6) begin
            ea = ~(4'b0001 << s);
            es = ex[s];
         end else begin
            ea = 4'b1111;
            es = 7'h7F;
         end
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL overwrite t=%0d: an=%b seg=%h want %b %h", t, an, seg, ea, es);
         end
         ticks(1);
      end
   endtask

   task automatic test_boundary_collision();
      logic [6:0] ex [4];
      reset_dut();
      lz_en = 1'b1;
      ticks(5);
      bus.load  = 1'b1;
      bus.value = 16'h1111;
      ticks(1);
      bus.load = 1'b0;
      ticks(27);
      bus.load  = 1'b1;
      bus.value = 16'h00F0;
      ticks(1);
      bus.load = 1'b0;
      checks++;
      if (bus.ack !== 1'b1 || frame !== 1'b1) begin
         errors++;
         $display("FAIL collision_ack: ack=%b frame=%b want 1 1", bus.ack, frame);
      end
      ex = '{7'h40, 7'h0E, 7'h7F, 7'h7F};
      for (int t = 0; t < 32; t++) begin
         int s;
         int o;
         logic [3:0] ea;
         logic [6:0] es;
         s = t / 8;
         o = t % 8;
         if (o < 6) begin
            ea = ~(4'b0001 << s);
            es = ex[s];
         end else begin
            ea = 4'b1111;
            es = 7'h7F;
         end
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL collision t=%0d: an=%b seg=%h want %b %h", t, an, seg, ea, es);
         end
         ticks(1);
      end
      checks++;
      if (bus.ack !== 1'b0 || frame !== 1'b1) begin
         errors++;
         $display("FAIL collision_next_frame: ack=%b frame=%b want 0 1", bus.ack, frame);
      end
      lz_en = 1'b0;
   endtask

   task automatic test_leading_zeros();
      logic [6:0] ex [4];
      reset_dut();
      lz_en = 1'b1;
      ticks(5);
      bus.load  = 1'b1;
      bus.value = 16'h0000;
      ticks(1);
      bus.load = 1'b0;
      ticks(28);
      checks++;
      if (bus.ack !== 1'b1) begin
         errors++;
         $display("FAIL lz_ack: ack=%b want 1", bus.ack);
      end
      ex = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
      for (int t = 0; t < 32; t++) begin
         int s;
         int o;
         logic [3:0] ea;
         logic [6:0] es;
         s = t / 8;
         o = t % 8;
         if (o < 6) begin
            ea = ~(4'b0001 << s);
            es = ex[s];
         end else begin
            ea = 4'b1111;
            es = 7'h7F;
         end
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL lz t=%0d: an=%b seg=%h want %b %h", t, an, seg, ea, es);
         end
         ticks(1);
      end
      ticks(8);
      checks++;
      if (an !== 4'b1101 || seg !== 7'h7F) begin
         errors++;
         $display("FAIL lz_digit1_blank: an=%b seg=%h want 1101 7f", an, seg);
      end
      lz_en = 1'b0;
      ticks(8);
      checks++;
      if (an !== 4'b1011 || seg !== 7'h40) begin
         errors++;
         $display("FAIL lz_off_digit2: an=%b seg=%h want 1011 40", an, seg);
      end
      ticks(8);
      checks++;
      if (an !== 4'b0111 || seg !== 7'h40) begin
         errors++;
         $display("FAIL lz_off_digit3: an=%b seg=%h want 0111 40", an, seg);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [6:0] ex [4];
      reset_dut();
      lz_en = 1'b0;
      ticks(5);
      bus.load  = 1'b1;
      bus.value = 16'h5678;
      ticks(1);
      bus.load = 1'b0;
      ticks(13);
      checks++;
      if (an !== 4'b1011 || seg !== 7'h40) begin
         errors++;
         $display("FAIL midrst_before: an=%b seg=%h want 1011 40", an, seg);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || frame !== 1'b0 || bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL midrst_off: an=%b seg=%h frame=%b ack=%b want 1111 7f 0 0", an, seg, frame, bus.ack);
      end
      ticks(3);
      rst = 1'b1;
      ticks(2);
      checks++;
      if (frame !== 1'b1 || bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL midrst_first_boundary: frame=%b ack=%b want 1 0", frame, bus.ack);
      end
      ex = '{7'h40, 7'h40, 7'h40, 7'h40};
      for (int t = 0; t < 32; t++) begin
         int s;
         int o;
         logic [3:0] ea;
         logic [6:0] es;
         s = t / 8;
         o = t % 8;
         if (o < 6) begin
            ea = ~(4'b0001 << s);
            es = ex[s];
         end else begin
            ea = 4'b1111;
            es = 7'h7F;
         end
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL midrst t=%0d: an=%b seg=%h want %b %h", t, an, seg, ea, es);
         end
         ticks(1);
      end
      checks++;
      if (bus.ack !== 1'b0 || frame !== 1'b1) begin
         errors++;
         $display("FAIL midrst_dropped: ack=%b frame=%b want 0 1", bus.ack, frame);
      end
   endtask

   // load held high while value changes every cycle: one ack per frame,
   // and each boundary takes the value present on that edge.
   task automatic test_back_to_back();
      int         acks;
      logic       ack34;
      logic [6:0] s35;
      logic [6:0] s43;
      reset_dut();
      lz_en    = 1'b0;
      bus.load = 1'b1;
      acks     = 0;
      ack34    = 1'b0;
      s35      = 7'h00;
      s43      = 7'h00;
      for (int k = 0; k < 66; k++) begin
         if (bus.ack === 1'b1) acks++;
         if (k == 34) ack34 = bus.ack;
         if (k == 35) s35 = seg;
         if (k == 43) s43 = seg;
         bus.value = 16'(16'h1000 + k);
         ticks(1);
      end
      checks++;
      if (acks !== 2 || ack34 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_acks: count=%0d ack34=%b want 2 1", acks, ack34);
      end
      checks++;
      if (s35 !== 7'h79 || s43 !== 7'h24) begin
         errors++;
         $display("FAIL b2b_shadow: d0=%h d1=%h want 79 24", s35, s43);
      end
      checks++;
      if (bus.ack !== 1'b1) begin
         errors++;
         $display("FAIL b2b_third_ack: ack=%b want 1", bus.ack);
      end
      bus.load = 1'b0;
      ticks(1);
      checks++;
      if (an !== 4'b1110 || seg !== 7'h79) begin
         errors++;
         $display("FAIL b2b_d0: an=%b seg=%h want 1110 79", an, seg);
      end
      ticks(8);
      checks++;
      if (an !== 4'b1101 || seg !== 7'h19) begin
         errors++;
         $display("FAIL b2b_d1: an=%b seg=%h want 1101 19", an, seg);
      end
      ticks(8);
      checks++;
      if (an !== 4'b1011 || seg !== 7'h40) begin
         errors++;
         $display("FAIL b2b_d2: an=%b seg=%h want 1011 40", an, seg);
      end
      ticks(8);
      checks++;
      if (an !== 4'b0111 || seg !== 7'h79) begin
         errors++;
         $display("FAIL b2b_d3: an=%b seg=%h want 0111 79", an, seg);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      lz_en     = 1'b0;
      bus.load  = 1'b0;
      bus.value = 16'h0000;
      test_reset();
      test_scan_order();
      test_overwrite();
      test_boundary_collision();
      test_leading_zeros();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display, which shares one segment bus across four anodes. It takes a 16-bit hex value from a counter or other datapath through a load handshake, and latches it into a shadow register only at frame boundaries, so a frame never shows a mix of old and new digits. It rotates the anodes with a blanking gap between digits to suppress ghosting, and optionally blanks leading zeros.

## Interface
- DIV, 50000: clock cycles per digit slot (SHOW + BLANK); requires DIV > BLANK.
- BLANK, 2000: cycles per slot with all anodes off; requires BLANK >= 1.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- value  input  16  hex value to display; nibble 3 (value[15:12]) drives digit 3 (leftmost).
- load  input  1  request to update the display with `value`; sampled every rising edge.
- lz_en  input  1  leading-zero blanking enable; sampled continuously.
- seg  output  7  segments, active-low, bit order gfedcba (seg[6]=g).
- an  output  4  anodes, active-low, an[i] selects digit i.
- ack  output  1  one-cycle pulse: shadow register updated.
- frame  output  1  one-cycle pulse: first cycle of each frame.

## Operation
- Registers:
  - state ∈ {SHOW, BLANK}.
  - idx: 2-bit digit index.
  - cnt: ceil(log2(DIV))-bit slot counter.
  - shadow: 16 bits, the displayed value.
  - capture: 16 bits.
  - pending: 1 bit.
- Reset state: state=BLANK, idx=3, cnt=0, shadow=0, capture=0, pending=0.
- SHOW: an = one-hot-low on idx; seg = decode(shadow nibble idx). Lasts DIV-BLANK cycles, then goes to BLANK with cnt=0.
- BLANK: an=4'b1111, seg=7'b1111111. Lasts BLANK cycles, then goes to SHOW with idx=idx+1 (3 wraps to 0) and cnt=0.
- Frame boundary: the edge that moves BLANK/idx=3 into SHOW/idx=0.
  - frame=1 for the first SHOW cycle of digit 0.
  - One frame = 4·DIV cycles.
- Load handshake:
  - Edge with load=1 away from a boundary: capture<=value, pending<=1.
  - A later load before the boundary overwrites capture (newest value wins).
- At a boundary edge:
  - If load=1: shadow<=value.
  - Else if pending=1: shadow<=capture.
  - In either case pending<=0 and ack=1 on the same cycle as frame.
  - With no load and no pending request, shadow holds and ack=0.
- Decode (hex, 7-bit):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, B→03, C→46, D→21, E→06, F→0E
- Leading-zero blanking, when lz_en=1:
  - Digit i (i=1..3) shows seg=7'b1111111 but keeps its anode active whenever shadow nibbles 3 down to i are all zero.
  - Digit 0 is never blanked.
- `value` is never displayed directly; only shadow drives seg.

## Timing
- an, seg, ack and frame are decoded from flops only; there is no combinational path from value, load or lz_en to any output, except lz_en to seg.
- During reset and for BLANK cycles after release: an=1111, seg=1111111, ack=0, frame=0.
- The first frame pulse comes BLANK cycles after rst deasserts. Shadow is still 0 at that point, so digit 0 shows 40.
- Load-to-display latency: between 1 and 4·DIV cycles, depending on where the request falls; ack marks the exact cycle.
- load held high continuously: capture tracks value every cycle; shadow takes the value present on the boundary edge; one ack per frame.
- Asynchronous reset mid-slot or mid-frame: immediate return to the reset state. The pending request is dropped, no ack is issued, and outputs go all-off within the reset assertion.
- Slot counter: counts 0..(DIV-BLANK-1) in SHOW and 0..(BLANK-1) in BLANK. It never exceeds its terminal count and carries no state across slots.

## Test plan
Bench uses DIV=8, BLANK=2; frame = 32 cycles.

1. **Reset.** Hold rst=0 for 5 cycles, then release.
   - an=1111 and seg=7F through the 2 cycles after release.
   - Cycle 3: an=1110, seg=40, frame=1, ack=0.
2. **Scan order.** load=1 for one cycle with value=16'h1234, away from a boundary.
   - ack and frame pulse together at the next boundary.
   - Per frame: digit 0 shows 19 for 6 cycles, then 2 blank cycles; digits 1, 2, 3 follow with 30, 24, 79 under an=1101, 1011, 0111.
3. **Overwrite.** Load 16'hAAAA, then 16'hBEEF, within the same frame.
   - Exactly one ack.
   - Display shows 0E, 06, 06, 03 on digits 0..3; 08 never appears.
4. **Boundary collision.** Assert load with 16'h00F0 exactly on the boundary edge while a pending 16'h1111 exists.
   - Shadow becomes 00F0 with one ack.
   - With lz_en=1: digits 3 and 2 show 7F with anodes still pulsing; digit 1 shows 0E; digit 0 shows 40.
5. **Leading zeros.** value=16'h0000 with lz_en=1.
   - Only digit 0 shows 40.
   - Toggling lz_en to 0 mid-frame shows 40 on the next digit slot.
6. **Reset mid-operation.** Pulse rst low during a SHOW slot of digit 2 while a load is pending.
   - Outputs go all-off immediately.
   - After release: shadow=0 with no ack at the first boundary; display shows 40 on digits 0..3 when lz_en=0.
